// File: rtl/glyph_serializer_pkg.sv
// Shared constants and fetch-FSM encoding for the glyph serializer.
package glyph_serializer_pkg;

    localparam int GLYPH_W_DEF = 10;
    localparam int ROW_W       = 4;
    localparam int CHAR_W      = 8;
    localparam int PIX_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/glyph_shift_reg.sv
// Glyph row shifter: MSB-first pixel output, pixel counter, and gapless reload
// from the hold register.
module glyph_shift_reg
    import glyph_serializer_pkg::*;
#(
    parameter int GLYPH_W = GLYPH_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic               hold_valid,
    input  logic [GLYPH_W-1:0] hold_data,
    output logic               load,
    output logic               empty,
    output logic               pixel_out,
    output logic               pixel_valid
);

    localparam logic [PIX_CNT_W-1:0] CNT_FULL = PIX_CNT_W'(GLYPH_W);
    localparam logic [PIX_CNT_W-1:0] CNT_ONE  = PIX_CNT_W'(1);

    logic [GLYPH_W-1:0]   shift_q, shift_d;
    logic [PIX_CNT_W-1:0] cnt_q, cnt_d;

    assign empty       = (cnt_q == '0);
    assign pixel_valid = !empty;
    assign pixel_out   = pixel_valid & shift_q[GLYPH_W-1];

    // Reload either into an empty shifter or on the edge that consumes the last pixel.
    assign load = hold_valid && (empty || (pix_en && cnt_q == CNT_ONE));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = hold_data;
            cnt_d   = CNT_FULL;
        end else if (pix_en && !empty) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/glyph_serializer.sv
// Character-cell pixel serializer: font fetch FSM plus glyph shifter.
// Optional GLYPH_SERIALIZER_INVERT_EN adds an INVERT input for inverse-video glyphs.
module glyph_serializer
    import glyph_serializer_pkg::*;
#(
    parameter int GLYPH_W  = GLYPH_W_DEF,
    parameter int FONT_LAT = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PIX_EN,
    input  logic [CHAR_W-1:0]  CHAR_IN,
    input  logic [ROW_W-1:0]   ROW_NUM,
    input  logic               CHAR_VALID,
`ifdef GLYPH_SERIALIZER_INVERT_EN
    input  logic               INVERT,
`endif
    output logic               CHAR_READY,
    output logic [CHAR_W-1:0]  FONT_CHAR,
    output logic [ROW_W-1:0]   FONT_ROW,
    input  logic [GLYPH_W-1:0] FONT_DATA,
    output logic               PIXEL_OUT,
    output logic               PIXEL_VALID,
    output logic               UNDERRUN
);

    localparam logic [1:0] LAT_LAST = 2'(FONT_LAT - 1);

    fetch_state_e       state_q, state_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [CHAR_W-1:0]  font_char_q, font_char_d;
    logic [ROW_W-1:0]   font_row_q, font_row_d;
    logic [GLYPH_W-1:0] hold_q, hold_d;
    logic               seen_q, seen_d;
    logic               underrun_q, underrun_d;
    logic               transfer, hold_valid, load, empty;
    logic [GLYPH_W-1:0] inv_mask;

    assign transfer   = CHAR_VALID && (state_q == ST_IDLE);
    assign hold_valid = (state_q == ST_HOLD);

`ifdef GLYPH_SERIALIZER_INVERT_EN
    logic inv_q, inv_d;

    assign inv_d    = transfer ? INVERT : inv_q;
    assign inv_mask = {GLYPH_W{inv_q}};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) inv_q <= 1'b0;
        else        inv_q <= inv_d;
    end
`else
    assign inv_mask = '0;
`endif

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        font_char_d = font_char_q;
        font_row_d  = font_row_q;
        hold_d      = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (CHAR_VALID) begin
                    state_d     = ST_WAIT;
                    lat_cnt_d   = '0;
                    font_char_d = CHAR_IN;
                    font_row_d  = ROW_NUM;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    hold_d  = FONT_DATA ^ inv_mask;
                    state_d = ST_HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (load) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        seen_d = seen_q | load;
        // Starving the shifter only counts once a glyph has actually been shown.
        underrun_d = underrun_q | (PIX_EN & empty & ~hold_valid & seen_q);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            font_char_q <= '0;
            font_row_q  <= '0;
            hold_q      <= '0;
            seen_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            font_char_q <= font_char_d;
            font_row_q  <= font_row_d;
            hold_q      <= hold_d;
            seen_q      <= seen_d;
            underrun_q  <= underrun_d;
        end
    end

    glyph_shift_reg #(
        .GLYPH_W(GLYPH_W)
    ) u_shift (
        .clk        (CLK),
        .rst_n      (RESET),
        .pix_en     (PIX_EN),
        .hold_valid (hold_valid),
        .hold_data  (hold_q),
        .load       (load),
        .empty      (empty),
        .pixel_out  (PIXEL_OUT),
        .pixel_valid(PIXEL_VALID)
    );

    assign CHAR_READY = (state_q == ST_IDLE);
    assign FONT_CHAR  = font_char_q;
    assign FONT_ROW   = font_row_q;
    assign UNDERRUN   = underrun_q;

endmodule
